wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, maximum consecutive cycles an MDU result waits before the pipeline is forced to stall; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_addr  input  5  MEM-stage destination register.
REQ-005 mem_wr_en  input  1  MEM-stage write request.
REQ-006 mem_data  input  32  MEM-stage write data.
REQ-007 mdu_valid  input  1  multiply/divide unit result pending.
REQ-008 mdu_addr  input  5  MDU destination register.
REQ-009 mdu_data  input  32  MDU result data.
REQ-010 mdu_ready  output  1  combinational grant to MDU; transfer occurs when mdu_valid and mdu_ready are both 1.
REQ-011 stall_req  output  1  registered request to freeze the pipeline at MEM.
REQ-012 wb_addr  output  5  register-file write address.
REQ-013 wb_en  output  1  register-file write enable.
REQ-014 wb_data  output  32  register-file write data.

Function
REQ-015 The block shall arbitrate the single register-file write port between the MEM stage and the MDU.
REQ-016 mem_eff shall be mem_wr_en and (mem_addr != 0); a request to register 0 is never a write.
REQ-017 In IDLE or WAIT, MEM shall have priority: mdu_ready = mdu_valid and not mem_eff.
REQ-018 In FORCE, mdu_ready shall equal mdu_valid regardless of MEM inputs; MEM inputs are ignored that cycle.
REQ-019 wb_addr/wb_en/wb_data shall be registered, with exactly one cycle of latency from the granting cycle.
REQ-020 The winner's addr/data shall be written with wb_en=1; with no winner, wb_en=0 and wb_addr/wb_data hold their previous values.
REQ-021 An MDU transfer with mdu_addr=0 shall complete the handshake but produce wb_en=0.
REQ-022 States: IDLE, WAIT, FORCE; wait_cnt is width $clog2(STARVE_LIMIT+1) and saturates at STARVE_LIMIT.
REQ-023 IDLE -> WAIT when mdu_valid and mem_eff, setting wait_cnt=1; otherwise stay in IDLE with wait_cnt=0.
REQ-024 WAIT -> IDLE on an MDU transfer or when mdu_valid drops, clearing wait_cnt.
REQ-025 WAIT -> FORCE when MDU is still blocked and wait_cnt==STARVE_LIMIT; otherwise increment wait_cnt.
REQ-026 stall_req shall be 1 exactly while in FORCE.
REQ-027 FORCE -> IDLE unconditionally after one cycle, clearing wait_cnt.
REQ-028 The MEM stage holds its inputs during stall_req, so the deferred MEM write wins the following cycle.
REQ-029 The MDU shall hold mdu_valid/addr/data stable until granted; the arbiter shall not buffer MDU data.
REQ-030 In FORCE with mdu_valid=0, no write shall occur and the state shall return to IDLE.

Reset
REQ-031 While reset=1 at a clock edge: state=IDLE, wait_cnt=0, stall_req=0, wb_en=0, wb_addr=0, wb_data=0.
REQ-032 mdu_ready shall be 0 while reset=1.
REQ-033 Reset mid-WAIT or mid-FORCE shall abandon the pending grant; a still-valid MDU shall re-arbitrate from IDLE after reset.

Configuration
REQ-034 Macro WB_ARB_STARVE_GUARD_EN: when defined, WAIT/FORCE, wait_cnt and stall_req shall behave as specified above.
REQ-035 When WB_ARB_STARVE_GUARD_EN is undefined: there is no FORCE state, stall_req is tied to 0, and the MDU is granted only on cycles with mem_eff=0.

Structure
REQ-036 Shared package mips_defs_pkg shall hold REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=5'd0 and the wb_arb_state_t enum (IDLE, WAIT, FORCE).
REQ-037 A single sub-module, wb_starve_timer, shall contain wait_cnt and the limit compare; the FSM and output registers stay in wb_arbiter.

Verification
REQ-038 Scenario: mem_wr_en=1, mem_addr=3, mem_data=0xDEADBEEF, mdu_valid=0 -> next cycle wb_en=1, wb_addr=3, wb_data=0xDEADBEEF.
REQ-039 Scenario: mem_wr_en=1, mem_addr=0 with mdu_valid=1, mdu_addr=5, mdu_data=0x12 -> mdu_ready=1 same cycle; next cycle wb_en=1, wb_addr=5, wb_data=0x12.
REQ-040 Scenario: STARVE_LIMIT=4, guard enabled, mem_eff=1 on every cycle, mdu_valid=1 -> stall_req=1 on cycle 5 after mdu_valid rises, MDU granted that cycle, stall_req=0 on cycle 6, and the held MEM write lands on the following cycle.
REQ-041 Scenario: guard disabled, same stimulus as REQ-040 -> stall_req never 1, mdu_ready stays 0 until mem_eff=0.
REQ-042 Scenario: reset=1 asserted while in WAIT with wait_cnt=3 -> next cycle state=IDLE, wb_en=0, stall_req=0, and counting restarts from 1.
REQ-043 Scenario: MDU transfer with mdu_addr=0 and mem idle -> mdu_ready=1, and wb_en=0 on the next cycle.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared register-file definitions and write-back arbiter state encoding.
package mips_defs_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } wb_arb_state_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the MEM stage / MDU (master) and the write-back arbiter (slave).
interface wb_arbiter_if;
  import mips_defs_pkg::*;

  logic [REG_ADDR_W-1:0] mem_addr;
  logic                  mem_wr_en;
  logic [REG_DATA_W-1:0] mem_data;
  logic                  mdu_valid;
  logic [REG_ADDR_W-1:0] mdu_addr;
  logic [REG_DATA_W-1:0] mdu_data;
  logic                  mdu_ready;
  logic                  stall_req;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic                  wb_en;
  logic [REG_DATA_W-1:0] wb_data;

  modport master (
    output mem_addr, mem_wr_en, mem_data, mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready, stall_req, wb_addr, wb_en, wb_data
  );

  modport slave (
    input  mem_addr, mem_wr_en, mem_data, mdu_valid, mdu_addr, mdu_data,
    output mdu_ready, stall_req, wb_addr, wb_en, wb_data
  );

endinterface

// File: rtl/wb_starve_timer.sv
// Counts consecutive cycles a pending MDU result has been blocked; saturates at STARVE_LIMIT.
module wb_starve_timer #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  output logic limit_hit
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q;

  // Anything other than load/inc clears the count.
  always_comb begin
    wait_cnt_d = {CNT_W{1'b0}};
    if (load) begin
      wait_cnt_d = CNT_W'(1'b1);
    end else if (inc && (wait_cnt_q != LIMIT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1'b1);
    end else if (inc) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = {CNT_W{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= {CNT_W{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign limit_hit = (wait_cnt_q == LIMIT);

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the single register-file write port between the MEM stage and the MDU.
// Starvation guard (FORCE state + stall_req) is built only when WB_ARB_STARVE_GUARD_EN is defined.
module wb_arbiter
  import mips_defs_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  wb_arb_state_t         state_d, state_q;
  logic                  stall_req_d, stall_req_q;
  logic                  wb_en_d, wb_en_q;
  logic [REG_ADDR_W-1:0] wb_addr_d, wb_addr_q;
  logic [REG_DATA_W-1:0] wb_data_d, wb_data_q;

  logic mem_eff, in_force, mdu_ready, mdu_xfer, mem_win;
  logic cnt_load, cnt_inc, limit_hit, guard_hit;

  wb_starve_timer #(.STARVE_LIMIT(STARVE_LIMIT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .inc       (cnt_inc),
    .limit_hit (limit_hit)
  );

`ifdef WB_ARB_STARVE_GUARD_EN
  assign guard_hit = limit_hit;
`else
  // Without the guard the MDU simply waits for a cycle with no MEM write.
  logic starve_unused;
  assign guard_hit     = 1'b0;
  assign starve_unused = limit_hit;
`endif

  // Grant decision, next state and write-port selection.
  always_comb begin
    mem_eff   = bus.mem_wr_en && (bus.mem_addr != ZERO_REG);
    in_force  = (state_q == FORCE);
    mdu_ready = !reset && bus.mdu_valid && (in_force || !mem_eff);
    mdu_xfer  = bus.mdu_valid && mdu_ready;
    mem_win   = mem_eff && !in_force;

    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mdu_valid && mem_eff) begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mdu_xfer || !bus.mdu_valid) begin
          state_d = IDLE;
        end else if (guard_hit) begin
          state_d = FORCE;
        end else begin
          state_d = WAIT;
          cnt_inc = 1'b1;
        end
      end
      FORCE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    stall_req_d = (state_d == FORCE);

    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (mem_win) begin
      wb_en_d   = 1'b1;
      wb_addr_d = bus.mem_addr;
      wb_data_d = bus.mem_data;
    end else if (mdu_xfer && (bus.mdu_addr != ZERO_REG)) begin
      wb_en_d   = 1'b1;
      wb_addr_d = bus.mdu_addr;
      wb_data_d = bus.mdu_data;
    end else begin
      wb_en_d = 1'b0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stall_req_q <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= ZERO_REG;
      wb_data_q   <= {REG_DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      stall_req_q <= stall_req_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign bus.mdu_ready = mdu_ready;
  assign bus.stall_req = stall_req_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expectations follow WB_ARB_STARVE_GUARD_EN.
module tb_wb_arbiter;

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_wr_en = 1'b0; bus.mem_addr = 5'd0; bus.mem_data = 32'd0;
    bus.mdu_valid = 1'b0; bus.mdu_addr = 5'd0; bus.mdu_data = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd1; bus.mdu_data = 32'h1;
    #1;
    checks++;
    if (bus.mdu_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%0b exp=0", bus.mdu_ready);
    end
    step();
    checks++;
    if ({bus.stall_req, bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b0, 1'b0, 5'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_outputs got=%0b/%0b/%0h/%0h exp=0/0/0/0",
               bus.stall_req, bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    step();
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_mem_write();
    bus.mem_wr_en = 1'b1; bus.mem_addr = 5'd3; bus.mem_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.mdu_ready !== 1'b0) begin
      failures++; $display("FAIL mem_ready got=%0b exp=0", bus.mdu_ready);
    end
    step();
    checks++;
    if ({bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL mem_wb got=%0b/%0h/%0h exp=1/3/deadbeef", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    bus.mem_addr = 5'd0; bus.mem_data = 32'h1111;
    step();
    checks++;
    if ({bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b0, 5'd3, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL mem_zero_hold got=%0b/%0h/%0h exp=0/3/deadbeef", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    idle_inputs();
  endtask

  task automatic test_mem_zero_mdu();
    bus.mem_wr_en = 1'b1; bus.mem_addr = 5'd0;
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd5; bus.mdu_data = 32'h12;
    #1;
    checks++;
    if (bus.mdu_ready !== 1'b1) begin
      failures++; $display("FAIL memzero_ready got=%0b exp=1", bus.mdu_ready);
    end
    step();
    checks++;
    if ({bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd5, 32'h12}) begin
      failures++;
      $display("FAIL memzero_wb got=%0b/%0h/%0h exp=1/5/12", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    idle_inputs();
  endtask

  task automatic test_mdu_zero();
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd0; bus.mdu_data = 32'h55;
    #1;
    checks++;
    if (bus.mdu_ready !== 1'b1) begin
      failures++; $display("FAIL mduzero_ready got=%0b exp=1", bus.mdu_ready);
    end
    step();
    checks++;
    if ({bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b0, 5'd5, 32'h12}) begin
      failures++;
      $display("FAIL mduzero_wb got=%0b/%0h/%0h exp=0/5/12", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    bus.mem_wr_en = 1'b1; bus.mem_addr = 5'd7; bus.mem_data = 32'hA5A5A5A5;
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd9; bus.mdu_data = 32'h99;
    #1;
    checks++;
    if (bus.mdu_ready !== 1'b0) begin
      failures++; $display("FAIL prio_ready_blocked got=%0b exp=0", bus.mdu_ready);
    end
    step();
    checks++;
    if ({bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd7, 32'hA5A5A5A5}) begin
      failures++;
      $display("FAIL prio_mem_wb got=%0b/%0h/%0h exp=1/7/a5a5a5a5", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    bus.mem_wr_en = 1'b0;
    #1;
    checks++;
    if (bus.mdu_ready !== 1'b1) begin
      failures++; $display("FAIL prio_ready_free got=%0b exp=1", bus.mdu_ready);
    end
    step();
    checks++;
    if ({bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd9, 32'h99}) begin
      failures++;
      $display("FAIL prio_mdu_wb got=%0b/%0h/%0h exp=1/9/99", bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    idle_inputs();
  endtask

  task automatic test_starve();
    logic        exp_stall, exp_ready;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    bus.mem_wr_en = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 32'h44444444;
    bus.mdu_addr  = 5'd6; bus.mdu_data = 32'h66666666;
    for (int c = 0; c <= 7; c++) begin
      bus.mdu_valid = GUARD ? (c <= 5) : 1'b1;
      #1;
      exp_stall = GUARD && (c == 5);
      exp_ready = GUARD && (c == 5);
      checks++;
      if ({bus.stall_req, bus.mdu_ready} !== {exp_stall, exp_ready}) begin
        failures++;
        $display("FAIL starve_c%0d stall/ready got=%0b/%0b exp=%0b/%0b",
                 c, bus.stall_req, bus.mdu_ready, exp_stall, exp_ready);
      end
      if (c >= 1) begin
        exp_addr = (GUARD && c == 6) ? 5'd6 : 5'd4;
        exp_data = (GUARD && c == 6) ? 32'h66666666 : 32'h44444444;
        checks++;
        if ({bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b1, exp_addr, exp_data}) begin
          failures++;
          $display("FAIL starve_wb_c%0d got=%0b/%0h/%0h exp=1/%0h/%0h",
                   c, bus.wb_en, bus.wb_addr, bus.wb_data, exp_addr, exp_data);
        end
      end
      step();
    end
    if (!GUARD) begin
      bus.mem_wr_en = 1'b0;
      #1;
      checks++;
      if (bus.mdu_ready !== 1'b1) begin
        failures++; $display("FAIL noguard_ready got=%0b exp=1", bus.mdu_ready);
      end
      step();
      checks++;
      if ({bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd6, 32'h66666666}) begin
        failures++;
        $display("FAIL noguard_wb got=%0b/%0h/%0h exp=1/6/66666666", bus.wb_en, bus.wb_addr, bus.wb_data);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_wait();
    logic        exp_stall;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    bus.mem_wr_en = 1'b1; bus.mem_addr = 5'd8; bus.mem_data = 32'h88;
    bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd10; bus.mdu_data = 32'hAA;
    step(); step(); step();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mdu_ready !== 1'b0) begin
      failures++; $display("FAIL midwait_reset_ready got=%0b exp=0", bus.mdu_ready);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.stall_req, bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b0, 1'b0, 5'd0, 32'd0}) begin
      failures++;
      $display("FAIL midwait_after_reset got=%0b/%0b/%0h/%0h exp=0/0/0/0",
               bus.stall_req, bus.wb_en, bus.wb_addr, bus.wb_data);
    end
    for (int c = 4; c <= 9; c++) begin
      exp_stall = GUARD && (c == 9);
      checks++;
      if (bus.stall_req !== exp_stall) begin
        failures++;
        $display("FAIL midwait_stall_c%0d got=%0b exp=%0b", c, bus.stall_req, exp_stall);
      end
      step();
    end
    exp_addr = GUARD ? 5'd10 : 5'd8;
    exp_data = GUARD ? 32'hAA : 32'h88;
    checks++;
    if ({bus.wb_en, bus.wb_addr, bus.wb_data} !== {1'b1, exp_addr, exp_data}) begin
      failures++;
      $display("FAIL midwait_wb got=%0b/%0h/%0h exp=1/%0h/%0h",
               bus.wb_en, bus.wb_addr, bus.wb_data, exp_addr, exp_data);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_mem_zero_mdu();
    test_mdu_zero();
    test_priority();
    test_starve();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
